reg_wb_ctrl: RTL and testbench
==============================

# reg_wb_ctrl

- Writeback controller in front of the single write port of `reg_file`.
- Merges two writeback sources, ALU results and variable-latency load returns, into at most one register write per cycle. Load returns always win; ALU results are buffered in a small FIFO.
- Keeps a per-register scoreboard of outstanding loads and reports read-operand hazards to the decode/issue logic.
- Sits between the execute/LSU stages and `reg_file`. Its `o_rd_*` outputs drive `reg_file` `i_rd_wren/i_rd_addr/i_rd_data` directly.

## Interface
- DATA_WIDTH, 32, register data width
- ADDR_WIDTH, 5, register address width
- NUM_REGS, 32, number of architectural registers (x0 hardwired zero)
- FIFO_DEPTH, 2, ALU writeback buffer entries (power of 2, ≥2)

Ports:
- i_clk  in  1  clock, all state updates on posedge
- i_rst_n  in  1  asynchronous active-low reset
- i_alu_vld  in  1  ALU result valid
- o_alu_rdy  out  1  ALU result accepted this cycle when high with i_alu_vld
- i_alu_rd  in  ADDR_WIDTH  ALU destination register
- i_alu_data  in  DATA_WIDTH  ALU result
- i_ld_issue  in  1  load issued to LSU this cycle (reserves destination)
- i_ld_issue_rd  in  ADDR_WIDTH  destination of issued load
- i_ld_vld  in  1  load response valid (always accepted, no ready)
- i_ld_rd  in  ADDR_WIDTH  load response destination
- i_ld_data  in  DATA_WIDTH  load response data
- i_rs1_addr, i_rs2_addr  in  ADDR_WIDTH each  operand addresses under decode
- o_rs1_pend, o_rs2_pend  out  1 each  operand has an uncommitted write
- o_busy_vec  out  NUM_REGS  scoreboard bits, bit 0 always 0
- o_rd_wren, o_rd_addr, o_rd_data  out  1/ADDR_WIDTH/DATA_WIDTH  registered write port to reg_file
- o_err_waw  out  1  one-cycle pulse: load issued to an already-busy register
- o_err_orphan  out  1  one-cycle pulse: load response to a non-busy register

## Operation
Arbitration, evaluated each cycle:
- If i_ld_vld, the load is selected.
- Else, if the FIFO is non-empty, the FIFO head is popped and selected.
- Else, if an ALU result is accepted this cycle, it is selected directly, bypassing the FIFO.
- An accepted ALU result that is not selected is pushed into the FIFO.
- The selected write is loaded into the output register: o_rd_wren=1 with its addr/data. When nothing is selected, o_rd_wren=0 and addr/data hold their previous values.

ALU handshake:
- o_alu_rdy = FIFO not full. It is a function of registered state only, with no combinational path from any input.

Writes to x0:
- ALU with rd=0: accepted, then dropped. No FIFO entry, no write.
- Load with rd=0: consumed, then dropped.

Scoreboard:
- A load issue with rd≠0 sets busy[rd].
- A selected load response clears busy[i_ld_rd].
- Issue and response to the same rd in the same cycle: busy stays 1, treated as a new reservation.
- Issue to an rd that is already busy: o_err_waw pulses, busy stays 1.
- Load response with busy[rd]=0 and rd≠0: the data is still written and o_err_orphan pulses.

Pending flag:
- o_rsN_pend = (addr≠0) & (busy[addr] | any valid FIFO entry rd==addr | (o_rd_wren & o_rd_addr==addr)).
- It is combinational on i_rsN_addr.

Ordering:
- ALU results commit in acceptance order.
- WAW ordering between loads and ALU results is the issuer's responsibility. The issuer must stall on o_rsN_pend/busy.

## Timing
- Latency: accept or response at edge N, then o_rd_wren high during cycle N+1. reg_file captures on its negedge within that cycle.
- An ALU result queued behind k FIFO entries or loads appears k cycles later.
- Reset (asynchronous, any time, including mid-drain):
  - FIFO emptied, busy_vec=0.
  - o_rd_wren=0, o_rd_addr=0, o_rd_data=0.
  - o_err_*=0, o_alu_rdy=1 after release.
  - Pending writes are discarded.
- Throughput: one register write per cycle, sustained.
- Continuous loads starve the FIFO. When the FIFO is full, ALU back-pressure holds.
- FIFO full with a simultaneous pop and push: not possible, because o_alu_rdy=0 when full.
- FIFO pointers: ADDR bits plus a wrap bit, wrapping modulo FIFO_DEPTH.

## Structure
- Package reg_wb_pkg:
  - DATA_WIDTH/ADDR_WIDTH/NUM_REGS constants
  - typedef wb_req_t {rd, data}
- Sub-module wb_fifo: synchronous FIFO of wb_req_t.
  - Outputs: full/empty, head, and per-entry valid+rd.
  - The per-entry outputs exist for the pending-flag compare.
- Top contains the arbiter, scoreboard, output register and error pulses.

## Test plan
- Reset, then three back-to-back ALU writes x1=0x11, x2=0x22, x3=0x33 → writes appear on cycles 1, 2, 3 after acceptance, in order; o_alu_rdy stays 1.
- Load response x5=0xDEAD together with ALU x6=0xBEEF, then two more ALU writes → x5 first, x6 next. FIFO fills, o_alu_rdy=0 for one cycle. Order is x5, x6, x7, x8.
- Issue load x7 → busy[7]=1 and o_rs1_pend=1 for rs1=7. Response x7=0x1234 three cycles later → busy cleared, write of 0x1234, pend drops after the write cycle.
- ALU write x0=0xFFFF and load x0 → no o_rd_wren; issue to x0 leaves busy_vec=0.
- Issue x9 twice without a response → o_err_waw pulses once. Response to x10 (not busy) → write occurs and o_err_orphan pulses.
- Assert i_rst_n=0 mid-stream with FIFO=2 and busy[4]=1 → all outputs reach reset values asynchronously, and no write follows release.

Source files
------------

// File: rtl/reg_wb_pkg.sv
// Shared constants and the writeback request type used by the writeback controller.
package reg_wb_pkg;

    localparam int DATA_WIDTH = 32;
    localparam int ADDR_WIDTH = 5;
    localparam int NUM_REGS   = 32;

    // One register write: destination and value
    typedef struct packed {
        logic [ADDR_WIDTH-1:0] rd;
        logic [DATA_WIDTH-1:0] data;
    } wb_req_t;

endpackage

// File: rtl/reg_wb_ctrl_wb_fifo.sv
// Small synchronous FIFO of writeback requests.
// The per-entry valid/rd outputs let the parent compare every queued
// destination against the operands under decode.
// Storage is a plain register array so that all entries can be read in parallel.
module wb_fifo
    import reg_wb_pkg::*;
#(
    parameter int DEPTH = 2
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  push,
    input  wb_req_t               push_data,
    input  logic                  pop,
    output logic                  full,
    output logic                  empty,
    output wb_req_t               head,
    output logic [DEPTH-1:0]      ent_vld,
    output logic [ADDR_WIDTH-1:0] ent_rd [DEPTH]
);

    localparam int PW = $clog2(DEPTH);

    // Pointers carry one extra wrap bit to tell full from empty
    logic [PW:0]   wr_ptr_reg;
    logic [PW:0]   rd_ptr_reg;
    logic [PW:0]   count;
    wb_req_t       mem_reg [DEPTH];

    assign count = wr_ptr_reg - rd_ptr_reg;
    assign empty = (wr_ptr_reg == rd_ptr_reg);
    assign full  = (wr_ptr_reg[PW] != rd_ptr_reg[PW]) &&
                   (wr_ptr_reg[PW-1:0] == rd_ptr_reg[PW-1:0]);
    assign head  = mem_reg[rd_ptr_reg[PW-1:0]];

    // An entry is live when its distance from the read pointer is below the fill count
    genvar gi;
    generate
        for (gi = 0; gi < DEPTH; gi++) begin : g_ent
            logic [PW-1:0] offset;
            assign offset      = PW'(gi) - rd_ptr_reg[PW-1:0];
            assign ent_vld[gi] = ({1'b0, offset} < count);
            assign ent_rd[gi]  = mem_reg[gi].rd;
        end
    endgenerate

    // Pointer update; reset discards every queued entry
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_reg <= '0;
            rd_ptr_reg <= '0;
        end else begin
            if (push && !full) wr_ptr_reg <= wr_ptr_reg + 1'b1;
            if (pop && !empty) rd_ptr_reg <= rd_ptr_reg + 1'b1;
        end
    end

    // Entry storage; contents need no reset because validity comes from the pointers
    always_ff @(posedge clk) begin
        if (push && !full) mem_reg[wr_ptr_reg[PW-1:0]] <= push_data;
    end

endmodule

// File: rtl/reg_wb_ctrl.sv
// Writeback controller: merges load returns and ALU results onto the single
// register-file write port, tracks outstanding loads and flags operand hazards.
module reg_wb_ctrl
    import reg_wb_pkg::*;
#(
    parameter int FIFO_DEPTH = 2
) (
    input  logic                  i_clk,
    input  logic                  i_rst_n,
    input  logic                  i_alu_vld,
    output logic                  o_alu_rdy,
    input  logic [ADDR_WIDTH-1:0] i_alu_rd,
    input  logic [DATA_WIDTH-1:0] i_alu_data,
    input  logic                  i_ld_issue,
    input  logic [ADDR_WIDTH-1:0] i_ld_issue_rd,
    input  logic                  i_ld_vld,
    input  logic [ADDR_WIDTH-1:0] i_ld_rd,
    input  logic [DATA_WIDTH-1:0] i_ld_data,
    input  logic [ADDR_WIDTH-1:0] i_rs1_addr,
    input  logic [ADDR_WIDTH-1:0] i_rs2_addr,
    output logic                  o_rs1_pend,
    output logic                  o_rs2_pend,
    output logic [NUM_REGS-1:0]   o_busy_vec,
    output logic                  o_rd_wren,
    output logic [ADDR_WIDTH-1:0] o_rd_addr,
    output logic [DATA_WIDTH-1:0] o_rd_data,
    output logic                  o_err_waw,
    output logic                  o_err_orphan
);

    logic                  fifo_full;
    logic                  fifo_empty;
    logic                  fifo_push;
    logic                  fifo_pop;
    wb_req_t               fifo_head;
    wb_req_t               alu_req;
    logic [FIFO_DEPTH-1:0] fifo_ent_vld;
    logic [ADDR_WIDTH-1:0] fifo_ent_rd [FIFO_DEPTH];

    logic                  alu_acc;
    logic                  alu_direct;

    logic                  wren_reg,   wren_next;
    wb_req_t               out_reg,    out_next;
    logic [NUM_REGS-1:0]   busy_reg,   busy_next;
    logic                  waw_reg,    waw_next;
    logic                  orphan_reg, orphan_next;

    // Ready depends only on the registered fill state, never on inputs
    assign o_alu_rdy  = ~fifo_full;
    assign alu_acc    = i_alu_vld & o_alu_rdy;
    // The FIFO is bypassed only when nothing older is waiting and no load claims the port
    assign alu_direct = alu_acc & ~i_ld_vld & fifo_empty;
    assign fifo_pop   = ~i_ld_vld & ~fifo_empty;
    // Results for x0 are accepted and silently dropped
    assign fifo_push  = alu_acc & ~alu_direct & (i_alu_rd != '0);
    assign alu_req    = '{rd: i_alu_rd, data: i_alu_data};

    wb_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
        .clk       (i_clk),
        .rst_n     (i_rst_n),
        .push      (fifo_push),
        .push_data (alu_req),
        .pop       (fifo_pop),
        .full      (fifo_full),
        .empty     (fifo_empty),
        .head      (fifo_head),
        .ent_vld   (fifo_ent_vld),
        .ent_rd    (fifo_ent_rd)
    );

    // Arbitration, scoreboard update and error detection for the next cycle
    always_comb begin
        wren_next   = 1'b0;
        out_next    = out_reg;
        busy_next   = busy_reg;
        waw_next    = 1'b0;
        orphan_next = 1'b0;

        if (i_ld_vld) begin
            if (i_ld_rd != '0) begin
                wren_next   = 1'b1;
                out_next    = '{rd: i_ld_rd, data: i_ld_data};
                orphan_next = ~busy_reg[i_ld_rd];
                busy_next[i_ld_rd] = 1'b0;
            end
        end else if (!fifo_empty) begin
            wren_next = 1'b1;
            out_next  = fifo_head;
        end else if (alu_direct && (i_alu_rd != '0)) begin
            wren_next = 1'b1;
            out_next  = alu_req;
        end

        // A new reservation applied after the clear wins when both hit the same register;
        // a response retiring the old reservation in the same cycle is not a WAW
        if (i_ld_issue && (i_ld_issue_rd != '0)) begin
            waw_next = busy_reg[i_ld_issue_rd] &
                       ~(i_ld_vld && (i_ld_rd == i_ld_issue_rd));
            busy_next[i_ld_issue_rd] = 1'b1;
        end
    end

    // Registered write port, scoreboard and error pulses
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            wren_reg   <= 1'b0;
            out_reg    <= '0;
            busy_reg   <= '0;
            waw_reg    <= 1'b0;
            orphan_reg <= 1'b0;
        end else begin
            wren_reg   <= wren_next;
            out_reg    <= out_next;
            busy_reg   <= busy_next;
            waw_reg    <= waw_next;
            orphan_reg <= orphan_next;
        end
    end

    // Operand hazard: outstanding load, queued ALU result, or write in flight to reg_file
    always_comb begin
        o_rs1_pend = busy_reg[i_rs1_addr] | (wren_reg && (out_reg.rd == i_rs1_addr));
        o_rs2_pend = busy_reg[i_rs2_addr] | (wren_reg && (out_reg.rd == i_rs2_addr));
        for (int i = 0; i < FIFO_DEPTH; i++) begin
            if (fifo_ent_vld[i] && (fifo_ent_rd[i] == i_rs1_addr)) o_rs1_pend = 1'b1;
            if (fifo_ent_vld[i] && (fifo_ent_rd[i] == i_rs2_addr)) o_rs2_pend = 1'b1;
        end
        if (i_rs1_addr == '0) o_rs1_pend = 1'b0;
        if (i_rs2_addr == '0) o_rs2_pend = 1'b0;
    end

    assign o_busy_vec   = busy_reg;
    assign o_rd_wren    = wren_reg;
    assign o_rd_addr    = out_reg.rd;
    assign o_rd_data    = out_reg.data;
    assign o_err_waw    = waw_reg;
    assign o_err_orphan = orphan_reg;

endmodule

// File: tb/tb_reg_wb_ctrl.sv
// Directed self-checking bench for reg_wb_ctrl.
module tb_reg_wb_ctrl;

    logic        i_clk = 1'b0;
    logic        i_rst_n;
    logic        i_alu_vld;
    logic        o_alu_rdy;
    logic [4:0]  i_alu_rd;
    logic [31:0] i_alu_data;
    logic        i_ld_issue;
    logic [4:0]  i_ld_issue_rd;
    logic        i_ld_vld;
    logic [4:0]  i_ld_rd;
    logic [31:0] i_ld_data;
    logic [4:0]  i_rs1_addr;
    logic [4:0]  i_rs2_addr;
    logic        o_rs1_pend;
    logic        o_rs2_pend;
    logic [31:0] o_busy_vec;
    logic        o_rd_wren;
    logic [4:0]  o_rd_addr;
    logic [31:0] o_rd_data;
    logic        o_err_waw;
    logic        o_err_orphan;

    int n_cmp = 0;
    int n_err = 0;

    always #5 i_clk = ~i_clk;

    reg_wb_ctrl #(.FIFO_DEPTH(2)) dut (
        .i_clk         (i_clk),
        .i_rst_n       (i_rst_n),
        .i_alu_vld     (i_alu_vld),
        .o_alu_rdy     (o_alu_rdy),
        .i_alu_rd      (i_alu_rd),
        .i_alu_data    (i_alu_data),
        .i_ld_issue    (i_ld_issue),
        .i_ld_issue_rd (i_ld_issue_rd),
        .i_ld_vld      (i_ld_vld),
        .i_ld_rd       (i_ld_rd),
        .i_ld_data     (i_ld_data),
        .i_rs1_addr    (i_rs1_addr),
        .i_rs2_addr    (i_rs2_addr),
        .o_rs1_pend    (o_rs1_pend),
        .o_rs2_pend    (o_rs2_pend),
        .o_busy_vec    (o_busy_vec),
        .o_rd_wren     (o_rd_wren),
        .o_rd_addr     (o_rd_addr),
        .o_rd_data     (o_rd_data),
        .o_err_waw     (o_err_waw),
        .o_err_orphan  (o_err_orphan)
    );

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
        end else begin
            $display("ok   %s = 0x%0h", tag, got);
        end
    endtask

    task automatic step();
        @(posedge i_clk);
        #1;
    endtask

    task automatic chk_wr(input string tag, input logic wren, input logic [4:0] addr,
                          input logic [31:0] data);
        chk({tag, ".wren"}, 64'(o_rd_wren), 64'(wren));
        chk({tag, ".addr"}, 64'(o_rd_addr), 64'(addr));
        chk({tag, ".data"}, 64'(o_rd_data), 64'(data));
    endtask

    task automatic idle();
        i_alu_vld     = 1'b0;
        i_alu_rd      = '0;
        i_alu_data    = '0;
        i_ld_issue    = 1'b0;
        i_ld_issue_rd = '0;
        i_ld_vld      = 1'b0;
        i_ld_rd       = '0;
        i_ld_data     = '0;
    endtask

    logic [4:0]  alu_rd_tab   [3] = '{5'd1, 5'd2, 5'd3};
    logic [31:0] alu_data_tab [3] = '{32'h11, 32'h22, 32'h33};

    initial begin
        idle();
        i_rs1_addr = '0;
        i_rs2_addr = '0;
        i_rst_n    = 1'b0;
        repeat (2) @(posedge i_clk);
        #1;
        chk("rst.wren", 64'(o_rd_wren), 64'd0);
        chk("rst.addr", 64'(o_rd_addr), 64'd0);
        chk("rst.data", 64'(o_rd_data), 64'd0);
        chk("rst.busy", 64'(o_busy_vec), 64'd0);
        chk("rst.rdy",  64'(o_alu_rdy), 64'd1);
        chk("rst.waw",  64'(o_err_waw), 64'd0);
        chk("rst.orph", 64'(o_err_orphan), 64'd0);
        #3 i_rst_n = 1'b1;
        step();

        // Three back-to-back ALU writes go straight through
        for (int i = 0; i < 3; i++) begin
            i_alu_vld  = 1'b1;
            i_alu_rd   = alu_rd_tab[i];
            i_alu_data = alu_data_tab[i];
            chk("alu.rdy", 64'(o_alu_rdy), 64'd1);
            step();
            chk_wr("alu", 1'b1, alu_rd_tab[i], alu_data_tab[i]);
        end
        idle();
        step();
        chk_wr("alu.idle", 1'b0, 5'd3, 32'h33);

        // Load beats ALU; a dropped x0 load lets the FIFO fill
        i_ld_vld = 1'b1; i_ld_rd = 5'd5; i_ld_data = 32'hDEAD;
        i_alu_vld = 1'b1; i_alu_rd = 5'd6; i_alu_data = 32'hBEEF;
        step();
        chk_wr("mix.x5", 1'b1, 5'd5, 32'hDEAD);
        chk("mix.rdy1", 64'(o_alu_rdy), 64'd1);
        i_ld_rd = 5'd0; i_ld_data = 32'h0;
        i_alu_rd = 5'd7; i_alu_data = 32'h77;
        i_rs2_addr = 5'd7;
        step();
        chk_wr("mix.ldx0", 1'b0, 5'd5, 32'hDEAD);
        chk("mix.rdy0", 64'(o_alu_rdy), 64'd0);
        chk("mix.pend7", 64'(o_rs2_pend), 64'd1);
        i_ld_vld = 1'b0;
        i_alu_rd = 5'd8; i_alu_data = 32'h88;
        step();
        chk_wr("mix.x6", 1'b1, 5'd6, 32'hBEEF);
        chk("mix.rdy2", 64'(o_alu_rdy), 64'd1);
        step();
        chk_wr("mix.x7", 1'b1, 5'd7, 32'h77);
        idle();
        step();
        chk_wr("mix.x8", 1'b1, 5'd8, 32'h88);
        step();
        chk("mix.done", 64'(o_rd_wren), 64'd0);
        i_rs2_addr = 5'd0;

        // Load scoreboard on x7
        i_rs1_addr = 5'd7;
        #1;
        chk("sb.pend0", 64'(o_rs1_pend), 64'd0);
        i_ld_issue = 1'b1; i_ld_issue_rd = 5'd7;
        step();
        idle();
        chk("sb.busy", 64'(o_busy_vec), 64'h80);
        chk("sb.pend1", 64'(o_rs1_pend), 64'd1);
        chk("sb.waw", 64'(o_err_waw), 64'd0);
        step();
        step();
        chk("sb.pend2", 64'(o_rs1_pend), 64'd1);
        i_ld_vld = 1'b1; i_ld_rd = 5'd7; i_ld_data = 32'h1234;
        step();
        idle();
        chk_wr("sb.resp", 1'b1, 5'd7, 32'h1234);
        chk("sb.clear", 64'(o_busy_vec), 64'd0);
        chk("sb.pendw", 64'(o_rs1_pend), 64'd1);
        chk("sb.orph", 64'(o_err_orphan), 64'd0);
        step();
        chk("sb.pendx", 64'(o_rs1_pend), 64'd0);
        chk("sb.nowr", 64'(o_rd_wren), 64'd0);
        i_rs1_addr = 5'd0;

        // x0 handling
        i_alu_vld = 1'b1; i_alu_rd = 5'd0; i_alu_data = 32'hFFFF;
        step();
        chk("x0.alu", 64'(o_rd_wren), 64'd0);
        idle();
        i_ld_issue = 1'b1; i_ld_issue_rd = 5'd0;
        step();
        idle();
        chk("x0.busy", 64'(o_busy_vec), 64'd0);
        chk("x0.pend", 64'(o_rs1_pend), 64'd0);

        // WAW and orphan errors
        i_ld_issue = 1'b1; i_ld_issue_rd = 5'd9;
        step();
        chk("err.waw0", 64'(o_err_waw), 64'd0);
        chk("err.busy9", 64'(o_busy_vec), 64'h200);
        step();
        idle();
        chk("err.waw1", 64'(o_err_waw), 64'd1);
        chk("err.busy9b", 64'(o_busy_vec), 64'h200);
        step();
        chk("err.waw2", 64'(o_err_waw), 64'd0);
        i_ld_vld = 1'b1; i_ld_rd = 5'd10; i_ld_data = 32'hA5;
        step();
        idle();
        chk_wr("err.x10", 1'b1, 5'd10, 32'hA5);
        chk("err.orph1", 64'(o_err_orphan), 64'd1);
        step();
        chk("err.orph0", 64'(o_err_orphan), 64'd0);

        // Asynchronous reset with a full FIFO and busy[4]
        i_ld_issue = 1'b1; i_ld_issue_rd = 5'd4;
        i_ld_vld = 1'b1; i_ld_rd = 5'd0;
        i_alu_vld = 1'b1; i_alu_rd = 5'd11; i_alu_data = 32'h111;
        step();
        i_ld_issue = 1'b0;
        i_alu_rd = 5'd12; i_alu_data = 32'h122;
        i_rs2_addr = 5'd12;
        step();
        idle();
        chk("rs.full", 64'(o_alu_rdy), 64'd0);
        chk("rs.busy4", 64'(o_busy_vec[4]), 64'd1);
        chk("rs.pend12", 64'(o_rs2_pend), 64'd1);
        #2 i_rst_n = 1'b0;
        #1;
        chk_wr("rs.async", 1'b0, 5'd0, 32'd0);
        chk("rs.busy", 64'(o_busy_vec), 64'd0);
        chk("rs.rdy", 64'(o_alu_rdy), 64'd1);
        chk("rs.pend", 64'(o_rs2_pend), 64'd0);
        step();
        #3 i_rst_n = 1'b1;
        step();
        chk_wr("rs.post1", 1'b0, 5'd0, 32'd0);
        step();
        chk("rs.post2", 64'(o_rd_wren), 64'd0);
        chk("rs.rdy2", 64'(o_alu_rdy), 64'd1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
